// File: rtl/axi_dbg_device_bridge.sv
// rtl/axi_dbg_device_bridge.sv - AXI4 slave to single-cycle debug device bridge
//
// Accepts one AXI4 read or write burst at a time and converts each beat into
// a one-cycle request on a simple debug device port. Read data from the
// device is valid exactly one cycle after the request.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   s_axi_aw*/w*/b*     - AXI4 write address, write data and write response
//   s_axi_ar*/r*        - AXI4 read address and read data
//   dbg_device_req      - one-cycle device access strobe
//   dbg_device_we       - 1 = write, 0 = read (only meaningful with req)
//   dbg_device_addr     - word-aligned device address
//   dbg_device_be       - byte enables
//   dbg_device_wdata    - write data
//   dbg_device_rdata    - read data, valid the cycle after req
module axi_dbg_device_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,

    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,

    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,

    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,

    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,

    output logic                dbg_device_req,
    output logic                dbg_device_we,
    output logic [ADDR_W-1:0]   dbg_device_addr,
    output logic [DATA_W/8-1:0] dbg_device_be,
    output logic [DATA_W-1:0]   dbg_device_wdata,
    input  logic [DATA_W-1:0]   dbg_device_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_MEM,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_MEM,
        WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    state_t              state_q,     state_d;
    logic                prio_q,      prio_d;     // 0 = read wins a tie, 1 = write
    logic [ID_W-1:0]     id_q,        id_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;     // address of the current beat
    logic [7:0]          len_q,       len_d;
    logic [7:0]          beat_q,      beat_d;
    logic [1:0]          burst_q,     burst_d;
    logic                err_q,       err_d;      // unsupported size/burst
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic [1:0]          rresp_q,     rresp_d;
    logic [1:0]          bresp_q,     bresp_d;
    logic [ADDR_W-1:0]   dev_addr_q,  dev_addr_d;
    logic [DATA_W/8-1:0] dev_be_q,    dev_be_d;
    logic [DATA_W-1:0]   dev_wdata_q, dev_wdata_d;

    logic                idle;
    logic                ar_hs;
    logic                aw_hs;
    logic                last_beat;
    logic                rd_err;
    logic                wr_err;
    logic [ADDR_W-1:0]   next_addr;

    assign idle      = (state_q == IDLE);
    assign last_beat = (beat_q == len_q);
    assign next_addr = (burst_q == BURST_INCR) ? addr_q + ADDR_W'(4) : addr_q;
    assign rd_err    = (s_axi_arsize != 3'b010) || s_axi_arburst[1];
    assign wr_err    = (s_axi_awsize != 3'b010) || s_axi_awburst[1];

    // With both channels valid only the prioritised one sees ready, so at
    // most one address handshake can happen per cycle.
    assign s_axi_arready = !rst && idle && !(s_axi_awvalid && prio_q);
    assign s_axi_awready = !rst && idle && !(s_axi_arvalid && !prio_q);
    assign ar_hs         = s_axi_arready && s_axi_arvalid;
    assign aw_hs         = s_axi_awready && s_axi_awvalid;

    assign s_axi_wready  = !rst && (state_q == WR_DATA);
    assign s_axi_bvalid  = !rst && (state_q == WR_RESP);
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = bresp_q;

    assign s_axi_rvalid  = !rst && (state_q == RD_DATA);
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = last_beat;

    assign dbg_device_req   = !rst && ((state_q == RD_MEM) ||
                                       ((state_q == WR_MEM) && !err_q));
    assign dbg_device_we    = !rst && (state_q == WR_MEM) && !err_q;
    assign dbg_device_addr  = dev_addr_q;
    assign dbg_device_be    = dev_be_q;
    assign dbg_device_wdata = dev_wdata_q;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        burst_d     = burst_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        bresp_d     = bresp_q;
        dev_addr_d  = dev_addr_q;
        dev_be_d    = dev_be_q;
        dev_wdata_d = dev_wdata_q;

        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    id_d    = s_axi_arid;
                    addr_d  = {s_axi_araddr[ADDR_W-1:2], 2'b00};
                    len_d   = s_axi_arlen;
                    burst_d = s_axi_arburst;
                    err_d   = rd_err;
                    beat_d  = 8'd0;
                    prio_d  = 1'b1;
                    if (rd_err) begin
                        // Error reads never touch the device.
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                        state_d = RD_DATA;
                    end else begin
                        dev_addr_d = {s_axi_araddr[ADDR_W-1:2], 2'b00};
                        dev_be_d   = '1;
                        state_d    = RD_MEM;
                    end
                end else if (aw_hs) begin
                    id_d    = s_axi_awid;
                    addr_d  = {s_axi_awaddr[ADDR_W-1:2], 2'b00};
                    len_d   = s_axi_awlen;
                    burst_d = s_axi_awburst;
                    err_d   = wr_err;
                    beat_d  = 8'd0;
                    prio_d  = 1'b0;
                    bresp_d = wr_err ? RESP_SLVERR : RESP_OKAY;
                    state_d = WR_DATA;
                end
            end

            RD_MEM: begin
                state_d = RD_WAIT;
            end

            RD_WAIT: begin
                rdata_d = dbg_device_rdata;
                rresp_d = RESP_OKAY;
                state_d = RD_DATA;
            end

            RD_DATA: begin
                if (s_axi_rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = next_addr;
                        // Error bursts stay here; rdata/rresp already hold 0/SLVERR.
                        if (!err_q) begin
                            dev_addr_d = next_addr;
                            dev_be_d   = '1;
                            state_d    = RD_MEM;
                        end
                    end
                end
            end

            WR_DATA: begin
                if (s_axi_wvalid) begin
                    if (!err_q) begin
                        dev_addr_d  = addr_q;
                        dev_be_d    = s_axi_wstrb;
                        dev_wdata_d = s_axi_wdata;
                    end
                    // The beat counter decides the burst length; a wlast that
                    // disagrees only poisons the response.
                    if (s_axi_wlast != last_beat) begin
                        bresp_d = RESP_SLVERR;
                    end
                    state_d = WR_MEM;
                end
            end

            WR_MEM: begin
                if (last_beat) begin
                    state_d = WR_RESP;
                end else begin
                    beat_d  = beat_q + 8'd1;
                    addr_d  = next_addr;
                    state_d = WR_DATA;
                end
            end

            WR_RESP: begin
                if (s_axi_bready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= 8'd0;
            beat_q      <= 8'd0;
            burst_q     <= 2'b00;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= 2'b00;
            bresp_q     <= 2'b00;
            dev_addr_q  <= '0;
            dev_be_q    <= '0;
            dev_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            bresp_q     <= bresp_d;
            dev_addr_q  <= dev_addr_d;
            dev_be_q    <= dev_be_d;
            dev_wdata_q <= dev_wdata_d;
        end
    end

endmodule

// File: tb/tb_axi_dbg_device_bridge.sv
// tb/tb_axi_dbg_device_bridge.sv - directed self-checking bench for axi_dbg_device_bridge
module tb_axi_dbg_device_bridge;

    logic        clk;
    logic        rst;
    logic [3:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        dbg_device_req;
    logic        dbg_device_we;
    logic [31:0] dbg_device_addr;
    logic [3:0]  dbg_device_be;
    logic [31:0] dbg_device_wdata;
    logic [31:0] dbg_device_rdata;

    axi_dbg_device_bridge #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .dbg_device_req(dbg_device_req), .dbg_device_we(dbg_device_we),
        .dbg_device_addr(dbg_device_addr), .dbg_device_be(dbg_device_be),
        .dbg_device_wdata(dbg_device_wdata), .dbg_device_rdata(dbg_device_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Device model: read data is pattern ^ address, valid only the cycle after req.
    logic [31:0] rd_pattern;
    always @(posedge clk) begin
        if (dbg_device_req && !dbg_device_we) dbg_device_rdata <= rd_pattern ^ dbg_device_addr;
        else                                  dbg_device_rdata <= 32'hDEAD_BEEF;
    end

    // Request monitor, sampled mid-cycle.
    logic [31:0] req_addr[$];
    logic        req_we[$];
    logic [3:0]  req_be[$];
    logic [31:0] req_wdata[$];
    always @(negedge clk) begin
        if (dbg_device_req) begin
            req_addr.push_back(dbg_device_addr);
            req_we.push_back(dbg_device_we);
            req_be.push_back(dbg_device_be);
            req_wdata.push_back(dbg_device_wdata);
        end
    end

    logic [31:0] got_data[$];
    logic [1:0]  got_resp[$];
    logic        got_last[$];
    logic [3:0]  got_rid[$];
    logic [1:0]  last_bresp;
    logic [3:0]  last_bid;
    int          req_base;
    int          n_pass;
    int          n_total;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic mark_req();
        req_base = req_addr.size();
    endtask

    function automatic int nreq();
        return req_addr.size() - req_base;
    endfunction

    task automatic clr_r();
        got_data.delete(); got_resp.delete(); got_last.delete(); got_rid.delete();
    endtask

    // Present an AR and return mid-cycle of the cycle after the handshake.
    task automatic ar_go(input [3:0] id, input [31:0] addr, input [7:0] len,
                         input [2:0] size, input [1:0] burst);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        #1;
        for (int k = 0; k < 64 && !s_axi_arready; k++) begin @(negedge clk); #1; end
        chk("ar_ready", s_axi_arready, 1'b1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        #1;
    endtask

    task automatic aw_go(input [3:0] id, input [31:0] addr, input [7:0] len,
                         input [2:0] size, input [1:0] burst);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        #1;
        for (int k = 0; k < 64 && !s_axi_awready; k++) begin @(negedge clk); #1; end
        chk("aw_ready", s_axi_awready, 1'b1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        #1;
    endtask

    task automatic r_beats(input int n);
        s_axi_rready = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 64 && !s_axi_rvalid; k++) begin @(negedge clk); #1; end
            if (!s_axi_rvalid) begin
                chk("r_timeout", s_axi_rvalid, 1'b1);
                break;
            end
            got_data.push_back(s_axi_rdata);
            got_resp.push_back(s_axi_rresp);
            got_last.push_back(s_axi_rlast);
            got_rid.push_back(s_axi_rid);
            @(negedge clk); #1;
        end
        s_axi_rready = 1'b0;
    endtask

    task automatic w_beats(input int n, input [31:0] base, input [3:0] strb, input int last_at);
        for (int i = 0; i < n; i++) begin
            s_axi_wdata = base + 32'(i); s_axi_wstrb = strb;
            s_axi_wlast = (i == last_at); s_axi_wvalid = 1'b1;
            #1;
            for (int k = 0; k < 64 && !s_axi_wready; k++) begin @(negedge clk); #1; end
            if (!s_axi_wready) begin
                chk("w_timeout", s_axi_wready, 1'b1);
                break;
            end
            @(negedge clk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic b_wait();
        s_axi_bready = 1'b1;
        for (int k = 0; k < 64 && !s_axi_bvalid; k++) begin @(negedge clk); #1; end
        chk("b_valid", s_axi_bvalid, 1'b1);
        last_bresp = s_axi_bresp;
        last_bid   = s_axi_bid;
        @(negedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    logic [7:0] grants;
    int         nr, nw, nlast;

    initial begin
        n_pass = 0; n_total = 0; req_base = 0;
        rd_pattern = 32'h0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'b010; s_axi_awburst = 2'b01;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'b010; s_axi_arburst = 2'b01;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        rst = 1'b1;
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        @(negedge clk); @(negedge clk); #1;

        // Reset state
        chk("rst_arready", s_axi_arready, 1'b0);
        chk("rst_rvalid", s_axi_rvalid, 1'b0);
        chk("rst_bvalid", s_axi_bvalid, 1'b0);
        chk("rst_req", dbg_device_req, 1'b0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_arready", s_axi_arready, 1'b1);
        chk("post_rst_dev_addr", dbg_device_addr, 32'h0);
        chk("post_rst_dev_be", dbg_device_be, 4'h0);
        chk("post_rst_rdata", s_axi_rdata, 32'h0);

        // Single read with exact latency
        rd_pattern = 32'hCAFE_F109;   // ^ 0x104 = 0xCAFEF00D
        mark_req();
        ar_go(4'd3, 32'h0000_0106, 8'd0, 3'b010, 2'b01);
        chk("rd1_req_t1", dbg_device_req, 1'b1);
        chk("rd1_addr_t1", dbg_device_addr, 32'h104);
        chk("rd1_we_t1", dbg_device_we, 1'b0);
        chk("rd1_be_t1", dbg_device_be, 4'hF);
        @(negedge clk); #1;
        chk("rd1_req_t2", dbg_device_req, 1'b0);
        chk("rd1_rvalid_t2", s_axi_rvalid, 1'b0);
        @(negedge clk); #1;
        chk("rd1_rvalid_t3", s_axi_rvalid, 1'b1);
        chk("rd1_rid", s_axi_rid, 4'd3);
        chk("rd1_rdata", s_axi_rdata, 32'hCAFE_F00D);
        chk("rd1_rresp", s_axi_rresp, 2'b00);
        chk("rd1_rlast", s_axi_rlast, 1'b1);
        @(negedge clk); #1;
        chk("rd1_hold_rvalid", s_axi_rvalid, 1'b1);
        chk("rd1_hold_rdata", s_axi_rdata, 32'hCAFE_F00D);
        s_axi_rready = 1'b1;
        @(negedge clk); #1;
        s_axi_rready = 1'b0;
        chk("rd1_done_rvalid", s_axi_rvalid, 1'b0);
        chk("rd1_nreq", nreq(), 1);

        // INCR write, len=3
        mark_req();
        aw_go(4'd5, 32'h400, 8'd3, 3'b010, 2'b01);
        w_beats(4, 32'h1111_0000, 4'hF, 3);
        b_wait();
        chk("wr_nreq", nreq(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_addr", req_addr[req_base+i], 32'h400 + 32'(4*i));
            chk("wr_we", req_we[req_base+i], 1'b1);
            chk("wr_data", req_wdata[req_base+i], 32'h1111_0000 + 32'(i));
            chk("wr_be", req_be[req_base+i], 4'hF);
        end
        chk("wr_bresp", last_bresp, 2'b00);
        chk("wr_bid", last_bid, 4'd5);

        // FIXED read, len=2
        rd_pattern = 32'h1234_0000;
        mark_req(); clr_r();
        ar_go(4'd7, 32'h380, 8'd2, 3'b010, 2'b00);
        r_beats(3);
        chk("fx_nreq", nreq(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("fx_addr", req_addr[req_base+i], 32'h380);
            chk("fx_data", got_data[i], 32'h1234_0380);
            chk("fx_resp", got_resp[i], 2'b00);
            chk("fx_last", got_last[i], (i == 2) ? 1'b1 : 1'b0);
            chk("fx_rid", got_rid[i], 4'd7);
        end

        // Arbitration: fresh reset, 4 back-to-back AR/AW pairs
        do_reset();
        clr_r();
        s_axi_arid = 4'd0; s_axi_araddr = 32'h100; s_axi_arlen = 8'd0; s_axi_arsize = 3'b010; s_axi_arburst = 2'b01;
        s_axi_awid = 4'd8; s_axi_awaddr = 32'h200; s_axi_awlen = 8'd0; s_axi_awsize = 3'b010; s_axi_awburst = 2'b01;
        s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1;
        #1;
        grants = 8'h00; nr = 1; nw = 1;
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 64 && !((s_axi_arready && s_axi_arvalid) || (s_axi_awready && s_axi_awvalid)); k++) begin
                @(negedge clk); #1;
            end
            if (s_axi_arready && s_axi_arvalid) begin
                grants[g] = 1'b1;
                @(negedge clk);
                if (nr < 4) begin s_axi_arid = 4'(nr); s_axi_araddr = 32'h100 + 32'(16*nr); nr++; end
                else s_axi_arvalid = 1'b0;
                #1;
                r_beats(1);
            end else if (s_axi_awready && s_axi_awvalid) begin
                @(negedge clk);
                if (nw < 4) begin s_axi_awid = 4'(8+nw); s_axi_awaddr = 32'h200 + 32'(16*nw); nw++; end
                else s_axi_awvalid = 1'b0;
                #1;
                w_beats(1, 32'hA000_0000, 4'hF, 0);
                b_wait();
            end else begin
                chk("arb_timeout", s_axi_arready | s_axi_awready, 1'b1);
                break;
            end
        end
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
        chk("arb_order", grants, 8'h55);
        chk("arb_rid3", got_rid[3], 4'd3);
        chk("arb_bid_last", last_bid, 4'd11);

        // Error: unsupported awsize
        mark_req();
        aw_go(4'd2, 32'h500, 8'd2, 3'b000, 2'b01);
        w_beats(3, 32'hBBBB_0000, 4'hF, 2);
        b_wait();
        chk("esz_nreq", nreq(), 0);
        chk("esz_bresp", last_bresp, 2'b10);
        chk("esz_bid", last_bid, 4'd2);

        // Error: WRAP read, len=1
        mark_req(); clr_r();
        ar_go(4'd4, 32'h600, 8'd1, 3'b010, 2'b10);
        r_beats(2);
        chk("ewr_nreq", nreq(), 0);
        chk("ewr_nbeats", got_data.size(), 2);
        for (int i = 0; i < 2; i++) begin
            chk("ewr_resp", got_resp[i], 2'b10);
            chk("ewr_data", got_data[i], 32'h0);
            chk("ewr_last", got_last[i], (i == 1) ? 1'b1 : 1'b0);
        end

        // Error: early wlast on a 2-beat write
        mark_req();
        aw_go(4'd6, 32'h700, 8'd1, 3'b010, 2'b01);
        w_beats(2, 32'hCCCC_0000, 4'h3, 0);
        b_wait();
        chk("ewl_bresp", last_bresp, 2'b10);
        chk("ewl_nreq", nreq(), 2);
        chk("ewl_be", req_be[req_base+1], 4'h3);

        // 256-beat INCR read crossing the top of the address space
        rd_pattern = 32'h0;
        mark_req(); clr_r();
        ar_go(4'd1, 32'hFFFF_FF80, 8'd255, 3'b010, 2'b01);
        r_beats(256);
        chk("l255_nreq", nreq(), 256);
        chk("l255_nbeats", got_data.size(), 256);
        chk("l255_wrap_addr", req_addr[req_base+32], 32'h0);
        chk("l255_last_addr", req_addr[req_base+255], 32'h37C);
        chk("l255_last_data", got_data[255], 32'h37C);
        nlast = 0;
        foreach (got_last[i]) if (got_last[i]) nlast++;
        chk("l255_nlast", nlast, 1);
        chk("l255_last_flag", got_last[255], 1'b1);

        // Reset while RD_DATA waits on rready
        rd_pattern = 32'h5555_0000;
        ar_go(4'd9, 32'h800, 8'd0, 3'b010, 2'b01);
        for (int k = 0; k < 64 && !s_axi_rvalid; k++) begin @(negedge clk); #1; end
        chk("rr_pre_rvalid", s_axi_rvalid, 1'b1);
        rst = 1'b1;
        mark_req();
        @(negedge clk); #1;
        chk("rr_rvalid_in_rst", s_axi_rvalid, 1'b0);
        s_axi_arid = 4'd1; s_axi_araddr = 32'h900; s_axi_arlen = 8'd0;
        s_axi_arsize = 3'b010; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        #1;
        chk("rr_arready_in_rst", s_axi_arready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rr_arready_after", s_axi_arready, 1'b1);
        chk("rr_no_req", nreq(), 0);
        chk("rr_rvalid_after", s_axi_rvalid, 1'b0);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        #1;
        clr_r();
        r_beats(1);
        chk("rr_new_rid", got_rid[0], 4'd1);
        chk("rr_new_data", got_data[0], 32'h5555_0900);
        chk("rr_new_nreq", nreq(), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_dbg_device_bridge.md
AXI_DBG_DEVICE_BRIDGE -- requirements
Module: axi_dbg_device_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI and device address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width; only 32 is supported.
REQ-003 SHALL have parameter ID_W, default 4: AXI ID width.
REQ-004 SHALL use one clock and a synchronous, active-high reset; there are no other clocks or resets.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-007 SHALL have the AW channel as inputs s_axi_awid (ID_W), awaddr (ADDR_W), awlen (8), awsize (3), awburst (2), awvalid (1), plus output s_axi_awready (1).
REQ-008 SHALL have the W channel as inputs s_axi_wdata (32), wstrb (4), wlast (1), wvalid (1), plus output s_axi_wready (1).
REQ-009 SHALL have the B channel as outputs s_axi_bid (ID_W), bresp (2), bvalid (1), plus input s_axi_bready (1).
REQ-010 SHALL have the AR channel as inputs s_axi_arid, araddr, arlen, arsize, arburst, arvalid, plus output s_axi_arready (1), with widths as on AW.
REQ-011 SHALL have the R channel as outputs s_axi_rid (ID_W), rdata (32), rresp (2), rlast (1), rvalid (1), plus input s_axi_rready (1).
REQ-012 SHALL have device outputs dbg_device_req (1), dbg_device_we (1), dbg_device_addr (ADDR_W), dbg_device_be (4) and dbg_device_wdata (32), plus input dbg_device_rdata (32), which is valid exactly one cycle after req.

Function
REQ-013 SHALL implement an FSM with states IDLE, RD_MEM, RD_WAIT, RD_DATA, WR_DATA, WR_MEM and WR_RESP, and SHALL allow only one transaction in flight.
REQ-014 SHALL assert awready/arready only in IDLE.
REQ-015 SHALL, in IDLE with only one of arvalid/awvalid high, grant that channel.
REQ-016 SHALL, in IDLE with both high, grant the channel selected by the prio bit; prio resets to read and toggles to the other channel after every grant.
REQ-017 SHALL, on an AR/AW handshake, latch id, word-aligned address (addr & ~3), len, burst and an error flag, and clear the 8-bit beat counter.
REQ-018 SHALL set the error flag when size != 3'b010 or burst is not FIXED (00) or INCR (01).
REQ-019 SHALL, after each beat, advance the address by +4 for INCR (wrapping modulo 2^ADDR_W) and leave it unchanged for FIXED.
REQ-020 SHALL run a non-error read as: AR handshake in cycle T, RD_MEM in T+1 (req=1, we=0, be=4'hF), RD_WAIT in T+2 capturing dbg_device_rdata into the rdata register, and RD_DATA from T+3 with rvalid=1.
REQ-021 SHALL hold rvalid and all R fields stable until rready.
REQ-022 SHALL assert rlast when beat count == len.
REQ-023 SHALL, on an R handshake, go to IDLE if rlast, otherwise to RD_MEM for the next beat.
REQ-024 SHALL give error reads rresp=2'b10 (SLVERR) and rdata=0 on all len+1 beats, skip RD_MEM/RD_WAIT, and leave req at 0.
REQ-025 SHALL, for writes, assert wready only in WR_DATA.
REQ-026 SHALL, on a W handshake, register wdata/wstrb and enter WR_MEM for one cycle with req=1, we=1 and be=wstrb; error writes keep req=0 in WR_MEM.
REQ-027 SHALL leave WR_MEM for WR_RESP when beat count == len, otherwise return to WR_DATA.
REQ-028 SHALL treat the beat counter as authoritative and set a sticky SLVERR if wlast disagrees with beat count == len on any beat.
REQ-029 SHALL, in WR_RESP, hold bvalid=1 with bid=latched id and bresp=OKAY (00), or SLVERR if the error flag is set, until bready, then go to IDLE.
REQ-030 SHALL assert dbg_device_req only in RD_MEM and WR_MEM, for exactly one cycle per beat.
REQ-031 SHALL, outside RD_MEM and WR_MEM, drive dbg_device_we low and hold addr/be/wdata at their last values.
REQ-032 SHALL support len=255 (256 beats) without counter overflow.

Reset
REQ-033 SHALL, while rst=1, force state to IDLE, prio to read, and all valid/ready/req/we outputs to 0.
REQ-034 SHALL, while rst=1, reset rdata, rresp, bresp, ids, addr, be and wdata registers to 0.
REQ-035 SHALL, on reset mid-transaction, drop the transaction with no further R/B beat or device req; awready/arready reassert in the first cycle after rst deasserts if the corresponding valid is high.

Verification
REQ-036 SHALL check a single read: AR id=3, addr=0x0000_0106, len=0, INCR; device returns 0xCAFE_F00D -> req in T+1 with addr=0x104, then R id=3, data=0xCAFE_F00D, OKAY, rlast=1 at T+3.
REQ-037 SHALL check an INCR write: AW addr=0x400, len=3, then 4 W beats with strb=0xF -> 4 single-cycle reqs with we=1 at 0x400/404/408/40C, then one B OKAY.
REQ-038 SHALL check a FIXED read: len=2 at 0x380 -> 3 reqs all at 0x380 and 3 R beats with rlast only on the third.
REQ-039 SHALL check simultaneous AR and AW in IDLE after reset -> read granted first, write granted after the read's rlast handshake, and grants alternate across 4 back-to-back pairs.
REQ-040 SHALL check error handling: awsize=3'b000 -> all W beats accepted with zero reqs and B SLVERR; WRAP read with len=1 -> 2 R beats with SLVERR and rdata=0; a write with early wlast -> B SLVERR.
REQ-041 SHALL check reset during RD_DATA with rready held low -> rvalid=0 the next cycle, no further req, and a new AR is accepted normally.
